// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light display path: controller state
// codes and seven-segment patterns (bit0 = a ... bit6 = g, bit7 = DP).
package traffic_pkg;

  localparam logic [1:0] A_GREEN  = 2'b00;
  localparam logic [1:0] A_YELLOW = 2'b01;
  localparam logic [1:0] B_GREEN  = 2'b10;
  localparam logic [1:0] B_YELLOW = 2'b11;

  localparam logic [7:0] SEG_0     = 8'h3f;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5b;
  localparam logic [7:0] SEG_3     = 8'h4f;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6d;
  localparam logic [7:0] SEG_6     = 8'h7d;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7f;
  localparam logic [7:0] SEG_9     = 8'h6f;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Map a BCD digit to its segment pattern; non-decimal codes go blank.
  function automatic logic [7:0] seg_code(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/timer_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// One capture cycle, eight shift cycles, one cycle to publish the digits.
module timer_bin2bcd (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bin,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Layout: {hundreds[1:0], tens[3:0], ones[3:0], binary[7:0]}
  logic [1:0]  r_state;
  logic [17:0] r_shift;
  logic [2:0]  r_bit_cnt;
  logic [17:0] w_adj;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  // Hundreds never reaches 5 for an 8-bit input, so only tens/ones adjust.
  assign w_adj[7:0]   = r_shift[7:0];
  assign w_adj[17:16] = r_shift[17:16];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_nibble
      localparam int LSB = 8 + 4 * gi;
      assign w_adj[LSB+3:LSB] = (r_shift[LSB+3:LSB] >= 4'd5) ?
                                (r_shift[LSB+3:LSB] + 4'd3) : r_shift[LSB+3:LSB];
    end
  endgenerate

  // Converter FSM: capture, shift eight times, then publish the digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      hundreds  <= '0;
      tens      <= '0;
      ones      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= {10'd0, bin};
            r_bit_cnt <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift   <= w_adj << 1;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          hundreds <= r_shift[17:16];
          tens     <= r_shift[15:12];
          ones     <= r_shift[11:8];
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/traffic_display_scan.sv
// Four-digit multiplexed seven-segment driver for the two-road controller.
// Digits 3..2 show road A, digits 1..0 show road B; the red road shows dashes.
module traffic_display_scan
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_DIV    = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] timer,
  input  logic [1:0] current_state,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       bcd_valid
);

  localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [7:0]         r_last_timer;
  logic               r_bcd_valid;
  logic [SLOT_W-1:0]  r_slot_cnt;
  logic [1:0]         r_digit_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic [7:0]         r_seg;
  logic [3:0]         r_an;

  logic               w_start;
  logic               w_busy;
  logic               w_done;
  logic [1:0]         w_hundreds;
  logic [3:0]         w_tens;
  logic [3:0]         w_ones;
  logic               w_road_a_active;
  logic               w_active_blank;
  logic [3:0][7:0]    w_digit_code;

  assign seg       = r_seg;
  assign an        = r_an;
  assign bcd_valid = r_bcd_valid;

  // Convert whenever the timer moved, or until a first result exists.
  assign w_start = !w_busy && ((timer != r_last_timer) || !r_bcd_valid);

  timer_bin2bcd u_bin2bcd (
    .clk      (clk),
    .reset    (reset),
    .bin      (timer),
    .start    (w_start),
    .busy     (w_busy),
    .done     (w_done),
    .hundreds (w_hundreds),
    .tens     (w_tens),
    .ones     (w_ones)
  );

  assign w_road_a_active = (current_state == A_GREEN) || (current_state == A_YELLOW);
  // The active road goes dark before the first result and in the yellow blink-off phase.
  assign w_active_blank  = !r_bcd_valid ||
                           (((current_state == A_YELLOW) || (current_state == B_YELLOW)) &&
                            r_blink_phase);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      localparam bit IS_ROAD_A = (gi >= 2);
      localparam bit IS_TENS   = ((gi % 2) == 1);
      assign w_digit_code[gi] =
        (w_road_a_active != IS_ROAD_A) ? SEG_DASH  :
        w_active_blank                 ? SEG_BLANK :
        (w_hundreds != 2'd0)           ? SEG_DASH  :
        IS_TENS ? ((w_tens == 4'd0) ? SEG_BLANK : seg_code(w_tens)) :
                  seg_code(w_ones);
    end
  endgenerate

  // Change detector: remember the value handed to the converter, flag first result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_timer <= '0;
      r_bcd_valid  <= 1'b0;
    end else begin
      if (w_start) r_last_timer <= timer;
      if (w_done)  r_bcd_valid  <= 1'b1;
    end
  end

  // Slot counter and digit index: 3 -> 2 -> 1 -> 0 -> 3 on each slot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= 2'd3;
    end else if (r_slot_cnt == SLOT_W'(SCAN_DIV - 1)) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= r_digit_idx - 2'd1;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  // Blink phase toggles once per BLINK_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Registered outputs: all anodes off during the ghosting guard, else the selected digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else if (r_slot_cnt < SLOT_W'(BLANK_CYCLES)) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(4'b0001 << r_digit_idx);
      r_seg <= w_digit_code[r_digit_idx];
    end
  end

endmodule

// File: tb/tb_traffic_display_scan.sv
// Scoreboard bench for traffic_display_scan with small scan/blink dividers.
module tb_traffic_display_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] timer = 8'd0;
  logic [1:0] current_state = 2'b00;
  logic [7:0] seg;
  logic [3:0] an;
  logic       bcd_valid;

  traffic_display_scan #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2),
    .BLINK_DIV    (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .timer         (timer),
    .current_state (current_state),
    .seg           (seg),
    .an            (an),
    .bcd_valid     (bcd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    bit         strict;
  } exp_t;

  exp_t sq[$];
  int   vq[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   base;

  // Rising edges since the last reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  // Monitor: pops an expectation at the first visible cycle of a matching slot.
  int   run = 0;
  bit   prev_valid = 1'b0;
  exp_t e;
  int   ev;
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
      prev_valid = 1'b0;
    end else begin
      if (bcd_valid && !prev_valid) begin
        checks++;
        if (vq.size() == 0) begin
          errors++;
          $display("FAIL bcd_valid_rise: rose at edge %0d, no rise expected", edge_n);
        end else begin
          ev = vq.pop_front();
          if (edge_n != ev) begin
            errors++;
            $display("FAIL bcd_valid_rise: rose at edge %0d, expected edge %0d", edge_n, ev);
          end else begin
            $display("bcd_valid rise at edge %0d ok", edge_n);
          end
        end
      end
      prev_valid = bcd_valid;
      if (an == 4'hF) begin
        run++;
      end else begin
        if (run > 0 && sq.size() > 0 && (sq[0].strict || sq[0].an == an)) begin
          e = sq.pop_front();
          if (e.strict) begin
            checks++;
            if (an !== e.an) begin
              errors++;
              $display("FAIL slot_an: got an=%b expected an=%b", an, e.an);
            end
          end
          checks++;
          if (seg !== e.seg) begin
            errors++;
            $display("FAIL slot_seg an=%b: got seg=%h expected seg=%h", e.an, seg, e.seg);
          end
          checks++;
          if (run != 2) begin
            errors++;
            $display("FAIL blank_run an=%b: got %0d blank cycles expected 2", an, run);
          end
          $display("slot edge=%0d an=%b seg=%h blank=%0d (expected seg=%h)",
                   edge_n, an, seg, run, e.seg);
        end
        run = 0;
      end
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("%s = %h ok", name, act);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] s, input bit strict);
    exp_t x;
    x.an = a;
    x.seg = s;
    x.strict = strict;
    sq.push_back(x);
  endtask

  task automatic drive_point();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_edge(input int n);
    int g = 0;
    while (edge_n < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (edge_n < n) begin
      checks++;
      errors++;
      $display("FAIL wait_edge: reached edge %0d expected %0d", edge_n, n);
    end
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    while ((sq.size() > 0 || vq.size() > 0) && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (sq.size() > 0 || vq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d slot and %0d valid expectations left, expected 0",
               sq.size(), vq.size());
      sq.delete();
      vq.delete();
    end
  endtask

  task automatic do_reset();
    wait_drain(200);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check8("reset_an", {4'd0, an}, 8'h0F);
    check8("reset_seg", seg, 8'h00);
    check8("reset_bcd_valid", {7'd0, bcd_valid}, 8'h00);
    vq.push_back(10);
    push(4'b0111, 8'h00, 1'b1);
    #1 reset = 1'b0;
  endtask

  initial begin
    // Reset then first conversion: timer 15 on A green.
    timer = 8'd15;
    current_state = 2'b00;
    do_reset();
    wait_edge(12);
    push(4'b0111, 8'h06, 1'b0);
    push(4'b1011, 8'h6d, 1'b0);
    push(4'b1101, 8'h40, 1'b0);
    push(4'b1110, 8'h40, 1'b0);
    wait_drain(100);

    // Leading-zero suppression: 5, then 0.
    drive_point();
    timer = 8'd5;
    base = edge_n;
    wait_edge(base + 12);
    push(4'b0111, 8'h00, 1'b0);
    push(4'b1011, 8'h6d, 1'b0);
    wait_drain(100);
    drive_point();
    timer = 8'd0;
    base = edge_n;
    wait_edge(base + 12);
    push(4'b0111, 8'h00, 1'b0);
    push(4'b1011, 8'h3f, 1'b0);
    wait_drain(100);

    // Yellow blink on A: phase 1 covers edges 64..127, phase 0 covers 128..191.
    timer = 8'd3;
    current_state = 2'b01;
    do_reset();
    wait_edge(60);
    push(4'b0111, 8'h00, 1'b0);
    push(4'b1011, 8'h00, 1'b0);
    push(4'b1101, 8'h40, 1'b0);
    push(4'b1110, 8'h40, 1'b0);
    wait_drain(100);
    wait_edge(100);
    push(4'b0111, 8'h00, 1'b0);
    push(4'b1011, 8'h4f, 1'b0);
    push(4'b1101, 8'h40, 1'b0);
    push(4'b1110, 8'h40, 1'b0);
    wait_drain(100);

    // Over-range on B green, then a normal B value.
    drive_point();
    current_state = 2'b10;
    timer = 8'd120;
    base = edge_n;
    wait_edge(base + 12);
    push(4'b0111, 8'h40, 1'b0);
    push(4'b1011, 8'h40, 1'b0);
    push(4'b1101, 8'h40, 1'b0);
    push(4'b1110, 8'h40, 1'b0);
    wait_drain(100);
    drive_point();
    timer = 8'd42;
    base = edge_n;
    wait_edge(base + 12);
    push(4'b0111, 8'h40, 1'b0);
    push(4'b1011, 8'h40, 1'b0);
    push(4'b1101, 8'h66, 1'b0);
    push(4'b1110, 8'h5b, 1'b0);
    wait_drain(100);

    // Timer changes during SHIFT: 12 captured at base+1, 9 three cycles later.
    drive_point();
    current_state = 2'b00;
    timer = 8'd12;
    base = edge_n;
    wait_edge(base + 3);
    #2 timer = 8'd9;
    wait_edge(base + 22);
    push(4'b0111, 8'h00, 1'b0);
    push(4'b1011, 8'h6f, 1'b0);
    wait_drain(100);

    // Asynchronous reset while digit 2 is lit.
    @(negedge clk);
    begin
      int g = 0;
      while (an !== 4'b1011 && g < 64) begin
        @(negedge clk);
        g++;
      end
    end
    check8("pre_reset_an", {4'd0, an}, 8'h0B);
    #2 reset = 1'b1;
    #1;
    check8("async_reset_an", {4'd0, an}, 8'h0F);
    check8("async_reset_seg", seg, 8'h00);
    check8("async_reset_bcd_valid", {7'd0, bcd_valid}, 8'h00);
    vq.push_back(10);
    push(4'b0111, 8'h00, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    wait_edge(14);
    push(4'b0111, 8'h00, 1'b0);
    push(4'b1011, 8'h6f, 1'b0);
    wait_drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
